// File: rtl/wb_master_interface_pkg.sv
// NIC-wide definitions shared by the WISHBONE master path.
// Contents: bus widths, WISHBONE cycle-type/burst-type codes, master FSM
// state encodings and the queue's maximum burst length.
package wb_master_interface_pkg;

    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / 8;
    localparam int MAX_BURST_LENGHT  = 127;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        WBM_IDLE    = 2'd0,
        WBM_REQ     = 2'd1,
        WBM_XFER    = 2'd2,
        WBM_BACKOFF = 2'd3
    } wbm_state_e;

endpackage

// File: rtl/wbm_backoff_counter.sv
// Retry back-off timer for the WISHBONE master.
// Ports: clk_i, rst_ni (async, active low), load_i (arm on RTY),
//        en_i (master is in BACKOFF), done_o (last back-off cycle).
// The master leaves BACKOFF through IDLE, and that IDLE cycle is part of the
// idle gap, so the counter is armed with BACKOFF_CYCLES-1 and done_o fires
// when one cycle remains. The smallest achievable gap is two cycles.
module wbm_backoff_counter #(
    parameter int BACKOFF_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);
    localparam int W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES + 1) : 1;
    localparam logic [W-1:0] LOAD = W'((BACKOFF_CYCLES > 1) ? BACKOFF_CYCLES - 1 : 0);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign done_o = en_i && (cnt_q <= W'(1));

endmodule

// File: rtl/wb_master_interface.sv
// WISHBONE B3 master fed by the PACKET2MESSAGE queue head.
// Turns one queued message (base address, chunked data, sel, we, burst
// length) into bus beats and hands per-beat handshakes back to the queue.
// Ports: clk/rst (async active low); queue side r_bus_arbitration_i,
//        address_i, data_i, sel_i, transaction_type_i, burst_lenght_i,
//        next_data_o, retry_o, message_transmitted_o; arbiter side
//        bus_req_o/bus_gnt_i; WISHBONE CYC/STB/WE/ADR/DAT/SEL/CTI/BTE,
//        DAT_I, ACK_I/RTY_I/ERR_I; reply side rd_data_o/rd_valid_o/
//        rd_last_o; err_o.
// Build option: WB_BURST_EN selects registered-feedback incrementing bursts
// (STB held, CTI 010/111); otherwise classic cycles with a one-cycle STB gap
// after every non-last ACK.
module wb_master_interface
    import wb_master_interface_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = $clog2(MAX_BURST_LENGHT + 1),
    parameter int BACKOFF_CYCLES      = 4,
    parameter int ADDR_STEP           = BUS_DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           r_bus_arbitration_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
    input  logic [BUS_DATA_WIDTH-1:0]      data_i,
    input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
    input  logic                           transaction_type_i,
    input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
    output logic                           next_data_o,
    output logic                           retry_o,
    output logic                           message_transmitted_o,
    output logic                           bus_req_o,
    input  logic                           bus_gnt_i,
    output logic                           CYC_O,
    output logic                           STB_O,
    output logic                           WE_O,
    output logic [BUS_ADDRESS_WIDTH-1:0]   ADR_O,
    output logic [BUS_DATA_WIDTH-1:0]      DAT_O,
    output logic [BUS_SEL_WIDTH-1:0]       SEL_O,
    output logic [2:0]                     CTI_O,
    output logic [1:0]                     BTE_O,
    input  logic [BUS_DATA_WIDTH-1:0]      DAT_I,
    input  logic                           ACK_I,
    input  logic                           RTY_I,
    input  logic                           ERR_I,
    output logic [BUS_DATA_WIDTH-1:0]      rd_data_o,
    output logic                           rd_valid_o,
    output logic                           rd_last_o,
    output logic                           err_o
);
    localparam int NB = N_BITS_BURST_LENGHT;

    wbm_state_e               state_q, state_d;
    logic [NB-1:0]            beat_q, beat_d;
    logic                     req_q, req_d, cyc_q, cyc_d, stb_q, stb_d;
    logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic                     err_q, err_d;
    logic                     bo_load, bo_done;
    logic [NB-1:0]            len_m1;
    logic                     last;

    // A zero burst length still moves one beat.
    assign len_m1 = (burst_lenght_i == '0) ? '0 : burst_lenght_i - NB'(1);
    assign last   = (beat_q == len_m1);

    wbm_backoff_counter #(.BACKOFF_CYCLES(BACKOFF_CYCLES)) u_backoff (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (bo_load),
        .en_i   (state_q == WBM_BACKOFF),
        .done_o (bo_done)
    );

    always_comb begin
        state_d               = state_q;
        beat_d                = beat_q;
        req_d                 = req_q;
        cyc_d                 = cyc_q;
        stb_d                 = stb_q;
        rd_data_d             = rd_data_q;
        rd_valid_d            = 1'b0;
        rd_last_d             = 1'b0;
        err_d                 = 1'b0;
        next_data_o           = 1'b0;
        retry_o               = 1'b0;
        message_transmitted_o = 1'b0;
        bo_load               = 1'b0;
        unique case (state_q)
            WBM_IDLE: begin
                if (r_bus_arbitration_i) begin
                    state_d = WBM_REQ;
                    req_d   = 1'b1;
                end
            end
            WBM_REQ: begin
                req_d = 1'b1;
                if (bus_gnt_i) begin
                    state_d = WBM_XFER;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    beat_d  = '0;
                end
            end
            WBM_XFER: begin
                // Slave responses only count while a strobe is presented;
                // the grant is deliberately not looked at here.
                if (stb_q) begin
                    if (ERR_I) begin
                        message_transmitted_o = 1'b1;
                        err_d   = 1'b1;
                        {req_d, cyc_d, stb_d} = 3'b000;
                        beat_d  = '0;
                        state_d = WBM_IDLE;
                    end else if (RTY_I) begin
                        retry_o = 1'b1;
                        bo_load = 1'b1;
                        {req_d, cyc_d, stb_d} = 3'b000;
                        beat_d  = '0;
                        state_d = WBM_BACKOFF;
                    end else if (ACK_I) begin
                        if (!transaction_type_i) begin
                            rd_data_d  = DAT_I;
                            rd_valid_d = 1'b1;
                            rd_last_d  = last;
                        end
                        if (last) begin
                            message_transmitted_o = 1'b1;
                            {req_d, cyc_d, stb_d} = 3'b000;
                            beat_d  = '0;
                            state_d = WBM_IDLE;
                        end else begin
                            next_data_o = 1'b1;
                            beat_d      = beat_q + NB'(1);
`ifndef WB_BURST_EN
                            stb_d       = 1'b0;
`endif
                        end
                    end
                end else begin
                    stb_d = 1'b1;  // end of the classic-cycle strobe gap
                end
            end
            WBM_BACKOFF: begin
                if (bo_done) state_d = WBM_IDLE;
            end
            default: state_d = WBM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WBM_IDLE;
            beat_q     <= '0;
            req_q      <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            req_q      <= req_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            err_q      <= err_d;
        end
    end

    assign bus_req_o  = req_q;
    assign CYC_O      = cyc_q;
    assign STB_O      = stb_q;
    assign WE_O       = cyc_q & transaction_type_i;
    assign ADR_O      = cyc_q ? address_i + BUS_ADDRESS_WIDTH'(beat_q) * BUS_ADDRESS_WIDTH'(ADDR_STEP) : '0;
    assign DAT_O      = cyc_q ? data_i : '0;
    assign SEL_O      = cyc_q ? sel_i  : '0;
`ifdef WB_BURST_EN
    assign CTI_O      = !cyc_q ? WB_CTI_CLASSIC : (last ? WB_CTI_EOB : WB_CTI_INCR);
`else
    assign CTI_O      = WB_CTI_CLASSIC;
`endif
    assign BTE_O      = WB_BTE_LINEAR;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_wb_master_interface.sv
module tb_wb_master_interface;
    import wb_master_interface_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arb = 1'b0, tt = 1'b0, gnt = 1'b0;
    logic [31:0] address = '0, data = '0;
    logic [3:0]  sel = '0;
    logic [6:0]  bl = '0;
    logic        ack_man = 1'b0, ack_auto = 1'b0, rty_man = 1'b0, err_man = 1'b0;

    logic        next_data, retry, mt, bus_req, CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O, DAT_I, rd_data;
    logic [3:0]  SEL_O;
    logic [2:0]  CTI_O;
    logic [1:0]  BTE_O;
    logic        ACK_I, rd_valid, rd_last, err_o;

    int checks = 0;
    int errors = 0;

    // Simple slave: optional auto-ACK on every strobe, read data tagged with the address.
    assign ACK_I = ack_man | (ack_auto & STB_O);
    assign DAT_I = {16'hD000, ADR_O[15:0]};

    always #5 clk = ~clk;

    wb_master_interface dut (
        .clk(clk), .rst(rst),
        .r_bus_arbitration_i(arb), .address_i(address), .data_i(data), .sel_i(sel),
        .transaction_type_i(tt), .burst_lenght_i(bl),
        .next_data_o(next_data), .retry_o(retry), .message_transmitted_o(mt),
        .bus_req_o(bus_req), .bus_gnt_i(gnt),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .SEL_O(SEL_O), .CTI_O(CTI_O), .BTE_O(BTE_O), .DAT_I(DAT_I),
        .ACK_I(ACK_I), .RTY_I(rty_man), .ERR_I(err_man),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_last_o(rd_last), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // IDLE -> REQ -> XFER; returns in the first XFER cycle.
    task automatic go_xfer(input logic [31:0] a, input logic t, input logic [6:0] len);
        arb = 1'b1; address = a; tt = t; bl = len; data = 32'h1234_5678; sel = 4'hF;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; arb = 1'b1;
        #1;
        checks++;
        if ({CYC_O, STB_O, bus_req, rd_valid, rd_last, err_o, next_data, retry, mt} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 000000000",
                {CYC_O, STB_O, bus_req, rd_valid, rd_last, err_o, next_data, retry, mt});
        end
        tick(); tick();
        checks++;
        if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req got %b want 0", bus_req); end
        rst = 1'b1; arb = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        arb = 1'b1; tt = 1'b1; bl = 7'd1; address = 32'h40; data = 32'hCAFE_0001; sel = 4'hF;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sw_idle_req got %b want 0", bus_req); end
        tick();
        checks++; if (bus_req !== 1'b1 || CYC_O !== 1'b0) begin errors++; $display("FAIL sw_req got req=%b cyc=%b want 1 0", bus_req, CYC_O); end
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0; ack_man = 1'b1;
        #1;
        checks++; if (CYC_O !== 1'b1 || WE_O !== 1'b1) begin errors++; $display("FAIL sw_cyc_we got %b%b want 11", CYC_O, WE_O); end
`ifdef WB_BURST_EN
        checks++; if (CTI_O !== 3'b111) begin errors++; $display("FAIL sw_cti got %b want 111", CTI_O); end
`else
        checks++; if (CTI_O !== 3'b000) begin errors++; $display("FAIL sw_cti got %b want 000", CTI_O); end
`endif
        checks++; if (mt !== 1'b1 || next_data !== 1'b0) begin errors++; $display("FAIL sw_handshake got mt=%b nd=%b want 1 0", mt, next_data); end
        checks++; if (ADR_O !== 32'h40 || DAT_O !== 32'hCAFE_0001) begin errors++; $display("FAIL sw_adr_dat got %h %h want 00000040 cafe0001", ADR_O, DAT_O); end
        tick();
        ack_man = 1'b0; arb = 1'b0;
        #1;
        checks++; if (CYC_O !== 1'b0 || bus_req !== 1'b0 || mt !== 1'b0) begin errors++; $display("FAIL sw_end got cyc=%b req=%b mt=%b want 0 0 0", CYC_O, bus_req, mt); end
        tick();
    endtask

    task automatic test_read_burst();
        logic        e_stb, e_nd, e_mt, e_rv, e_rl, e_cyc;
        logic [2:0]  e_cti;
        logic [31:0] e_adr, e_rd;
        int          n_nd, n_mt, n_rv;
`ifdef WB_BURST_EN
        int nc = 4;
`else
        int nc = 7;
`endif
        n_nd = 0; n_mt = 0; n_rv = 0;
        go_xfer(32'h100, 1'b0, 7'd4);
        ack_auto = 1'b1;
        for (int i = 0; i <= nc; i++) begin
            #1;
            e_cyc = (i < nc);
`ifdef WB_BURST_EN
            e_stb = (i < 4);
            e_adr = 32'h100 + 32'(4 * i);
            e_nd  = (i < 3);
            e_mt  = (i == 3);
            e_cti = (i < 3) ? 3'b010 : 3'b111;
            e_rv  = (i >= 1);
            e_rl  = (i == 4);
            e_rd  = 32'hD000_0100 + 32'(4 * (i - 1));
`else
            e_stb = (i < 7) && (i % 2 == 0);
            e_adr = 32'h100 + 32'(4 * ((i + 1) / 2));
            e_nd  = (i < 6) && (i % 2 == 0);
            e_mt  = (i == 6);
            e_cti = 3'b000;
            e_rv  = (i % 2 == 1);
            e_rl  = (i == 7);
            e_rd  = 32'hD000_0100 + 32'(4 * ((i - 1) / 2));
`endif
            n_nd += int'(next_data); n_mt += int'(mt); n_rv += int'(rd_valid);
            checks++; if (CYC_O !== e_cyc || STB_O !== e_stb) begin errors++; $display("FAIL rd_cyc_stb[%0d] got %b%b want %b%b", i, CYC_O, STB_O, e_cyc, e_stb); end
            checks++; if (next_data !== e_nd || mt !== e_mt) begin errors++; $display("FAIL rd_hs[%0d] got nd=%b mt=%b want %b %b", i, next_data, mt, e_nd, e_mt); end
            checks++; if (rd_valid !== e_rv || rd_last !== e_rl) begin errors++; $display("FAIL rd_valid_last[%0d] got %b%b want %b%b", i, rd_valid, rd_last, e_rv, e_rl); end
            if (e_cyc) begin
                checks++; if (ADR_O !== e_adr || CTI_O !== e_cti || WE_O !== 1'b0) begin errors++; $display("FAIL rd_adr_cti[%0d] got %h %b we=%b want %h %b 0", i, ADR_O, CTI_O, WE_O, e_adr, e_cti); end
            end
            if (e_rv) begin
                checks++; if (rd_data !== e_rd) begin errors++; $display("FAIL rd_data[%0d] got %h want %h", i, rd_data, e_rd); end
            end
            if (e_mt) arb = 1'b0;
            tick();
        end
        ack_auto = 1'b0;
        checks++; if (n_nd != 3 || n_mt != 1 || n_rv != 4) begin errors++; $display("FAIL rd_counts got nd=%0d mt=%0d rv=%0d want 3 1 4", n_nd, n_mt, n_rv); end
    endtask

    task automatic test_retry();
        bit found = 0;
        bit done  = 0;
        go_xfer(32'h200, 1'b1, 7'd4);
        for (int c = 0; c < 16 && !found; c++) begin
            ack_man = STB_O && (ADR_O != 32'h208);
            rty_man = STB_O && (ADR_O == 32'h208);
            #1;
            if (rty_man) begin
                found = 1;
                checks++; if (retry !== 1'b1 || next_data !== 1'b0 || mt !== 1'b0) begin errors++; $display("FAIL rty_hs got r=%b nd=%b mt=%b want 1 0 0", retry, next_data, mt); end
            end
            tick();
        end
        ack_man = 1'b0; rty_man = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL rty_reach_beat2 got none want retry at 00000208"); end
        #1;
        checks++; if (CYC_O !== 1'b0 || retry !== 1'b0) begin errors++; $display("FAIL rty_drop got cyc=%b r=%b want 0 0", CYC_O, retry); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rty_backoff[%0d] got req=%b want 0", k, bus_req); end
            tick();
        end
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rty_rereq got req=%b want 1", bus_req); end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        checks++; if (CYC_O !== 1'b1 || ADR_O !== 32'h200) begin errors++; $display("FAIL rty_restart got cyc=%b adr=%h want 1 00000200", CYC_O, ADR_O); end
        for (int c = 0; c < 20 && !done; c++) begin
            ack_man = STB_O;
            #1;
            if (mt) begin done = 1; arb = 1'b0; end
            tick();
        end
        ack_man = 1'b0; arb = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL rty_complete got no transmitted want 1"); end
        tick();
    endtask

    task automatic test_err_ack();
        go_xfer(32'h300, 1'b1, 7'd2);
        ack_man = 1'b1; err_man = 1'b1;
        #1;
        checks++; if (mt !== 1'b1 || next_data !== 1'b0 || retry !== 1'b0) begin errors++; $display("FAIL err_prio got mt=%b nd=%b r=%b want 1 0 0", mt, next_data, retry); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_early got %b want 0", err_o); end
        tick();
        ack_man = 1'b0; err_man = 1'b0; arb = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1 || CYC_O !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL err_pulse got err=%b cyc=%b req=%b want 1 0 0", err_o, CYC_O, bus_req); end
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", err_o); end
    endtask

    task automatic test_async_reset();
        go_xfer(32'h400, 1'b1, 7'd4);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        #1;
        checks++; if (CYC_O !== 1'b1 || ADR_O !== 32'h404) begin errors++; $display("FAIL ar_pre got cyc=%b adr=%h want 1 00000404", CYC_O, ADR_O); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({CYC_O, STB_O, bus_req, next_data, retry, mt} !== 6'b0) begin errors++; $display("FAIL ar_drop got %b want 000000", {CYC_O, STB_O, bus_req, next_data, retry, mt}); end
        tick();
        rst = 1'b1; arb = 1'b0;
        tick();
        arb = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0 || CYC_O !== 1'b0) begin errors++; $display("FAIL ar_idle got req=%b cyc=%b want 0 0", bus_req, CYC_O); end
        tick();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ar_req got %b want 1", bus_req); end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        checks++; if (ADR_O !== 32'h400 || CYC_O !== 1'b1) begin errors++; $display("FAIL ar_beat0 got adr=%h cyc=%b want 00000400 1", ADR_O, CYC_O); end
        arb = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single_write();
        test_read_burst();
        test_retry();
        test_err_ack();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_master_interface.md
Name: wb_master_interface

Overview:
- WISHBONE B3 master FSM directly downstream of the PACKET2MESSAGE message queue; turns the queued head message (address, data chunks, sel, we, burst length) into bus cycles.
- Returns per-beat handshakes to the queue (next chunk, retry, transmitted) and captures read-reply beats for the reply path.
- One per NIC.

Parameters:
- N_BITS_BURST_LENGHT, 7, width of burst_lenght_i and of the internal beat counter.
- BACKOFF_CYCLES, 4, idle cycles after RTY_I before re-requesting the bus (min 1).
- ADDR_STEP, 4, byte increment of ADR_O per beat (BUS_DATA_WIDTH/8).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- r_bus_arbitration_i  input  1  queue holds a message.
- address_i  input  BUS_ADDRESS_WIDTH  base address of message.
- data_i  input  BUS_DATA_WIDTH  current chunk.
- sel_i  input  BUS_SEL_WIDTH  current byte select.
- transaction_type_i  input  1  1=write, 0=read.
- burst_lenght_i  input  N_BITS_BURST_LENGHT  beats in message.
- next_data_o  output  1  advance queue chunk pointer.
- retry_o  output  1  rewind queue chunk pointer.
- message_transmitted_o  output  1  pop queue head.
- bus_req_o  output  1  request to bus arbiter.
- bus_gnt_i  input  1  grant from bus arbiter.
- CYC_O, STB_O, WE_O  output  1  WISHBONE.
- ADR_O  output  BUS_ADDRESS_WIDTH.
- DAT_O  output  BUS_DATA_WIDTH.
- SEL_O  output  BUS_SEL_WIDTH.
- CTI_O  output  3; BTE_O  output  2.
- DAT_I  input  BUS_DATA_WIDTH.
- ACK_I, RTY_I, ERR_I  input  1.
- rd_data_o  output  BUS_DATA_WIDTH  captured read beat.
- rd_valid_o  output  1  rd_data_o valid (one-cycle pulse).
- rd_last_o  output  1  qualifies last read beat.
- err_o  output  1  one-cycle pulse: message dropped on ERR_I.

Behaviour:
- Reset (rst low, async): state=IDLE, beat=0, backoff=0; all registered outputs 0 (bus_req_o, CYC_O, STB_O, rd_*, err_o).
- States: IDLE, REQ, XFER, BACKOFF.
  - IDLE: if r_bus_arbitration_i, go to REQ with bus_req_o=1.
  - REQ: hold bus_req_o. On bus_gnt_i, go to XFER: CYC_O=STB_O=1 registered, beat=0.
  - XFER: bus_req_o stays 1. A grant drop mid-XFER is ignored; the cycle is always finished.
  - BACKOFF: count BACKOFF_CYCLES, then go to IDLE.
- Combinational outputs while CYC_O=1:
  - WE_O=transaction_type_i, DAT_O=data_i, SEL_O=sel_i.
  - ADR_O=address_i+beat*ADDR_STEP, truncated to BUS_ADDRESS_WIDTH.
- Effective length L = burst_lenght_i, or 1 if burst_lenght_i=0.
- In XFER, per cycle, priority ERR_I > RTY_I > ACK_I (lower-priority inputs ignored):
  - ACK_I && beat<L-1: next_data_o=1 (combinational, same cycle); beat+1. The queue pointer updates on the same edge, so data_i is correct on the next beat.
  - ACK_I && beat==L-1: message_transmitted_o=1, next_data_o=0. Drop CYC_O/STB_O/bus_req_o next edge; go to IDLE. The next message needs at least one IDLE cycle.
  - RTY_I: retry_o=1, beat=0; drop CYC/STB/req; go to BACKOFF.
  - ERR_I: message_transmitted_o=1, err_o pulses next cycle; drop cycle; go to IDLE.
- Read capture: on each ACK_I with WE_O=0, register DAT_I into rd_data_o. rd_valid_o=1 next cycle; rd_last_o=1 if that beat was L-1.
- next_data_o, retry_o and message_transmitted_o are mutually exclusive and are 0 outside XFER.
- Reset asserted mid-XFER: CYC_O drops immediately and the queue is not notified (the queue shares the reset domain).

Optional Feature:
- Macro WB_BURST_EN.
- Defined:
  - Registered-feedback incrementing burst.
  - STB_O held across beats.
  - CTI_O=3'b010, and 3'b111 on beat L-1 (3'b111 when L=1).
  - BTE_O=2'b00.
- Undefined:
  - Classic cycles; CTI_O=3'b000, BTE_O=2'b00.
  - STB_O deasserts for exactly one cycle after every non-last ACK, with CYC_O held.
  - Throughput is one beat per two cycles minimum.

Decomposition:
- Add to NIC-defines package: WB_CTI_CLASSIC/INCR/EOB and WB_BTE_LINEAR constants, FSM state encodings (2-bit WBM_IDLE/REQ/XFER/BACKOFF), MAX_BURST_LENGHT reuse.
- One natural sub-module: wbm_backoff_counter (load, count down, done pulse).

Test Plan:
- Write, L=1, gnt after 2 cycles, ACK in first XFER cycle:
  - CYC_O high exactly 1 cycle, WE_O=1, CTI_O=111.
  - message_transmitted_o pulse, no next_data_o.
- Read, L=4, address_i=0x100, ACK every cycle (WB_BURST_EN):
  - ADR_O=0x100/104/108/10C, 3 next_data_o pulses, 1 message_transmitted_o.
  - 4 rd_valid_o pulses, rd_last_o on 4th; CTI_O 010,010,010,111.
- Same read without WB_BURST_EN:
  - STB_O pattern 1,0,1,0,1,0,1; CYC_O continuously high; same ADR sequence.
- RTY_I on beat 2 of L=4 write:
  - retry_o pulse, CYC_O low next cycle.
  - bus_req_o low for 4 cycles, re-request; restart at ADR=base.
- ERR_I and ACK_I together on beat 0:
  - ERR wins: message_transmitted_o=1, next_data_o=0, err_o pulse next cycle.
- Async reset asserted mid-burst:
  - CYC_O/STB_O/bus_req_o go 0 without a clock edge.
  - After release, IDLE and beat=0.
